shift_rgst: RTL

//   Parametrised multi-mode shift register; next generation of the load/clear register.

---
 rtl/shift_rgst_pkg.sv | 27 ++
 rtl/shift_rgst_if.sv | 34 +++
 rtl/shift_rgst_step.sv | 48 ++++
 rtl/shift_rgst.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shift_rgst_pkg.sv
// Shared definitions for the shift_rgst register: op codes, FSM state
// encoding and the derivation of the shift-count width.
package shift_rgst_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Count width wide enough to hold the value w itself (and beyond).
    function automatic int calc_aw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_rgst_if.sv
// Bundle of the control, data and status signals of shift_rgst.
// The parity output exists only when SHIFT_RGST_PARITY_EN is defined.
interface shift_rgst_if #(
    parameter int W = 8
);
    import shift_rgst_pkg::*;

    localparam int AW = calc_aw(W);

    logic          clr;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          sin;
    logic [W-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;
`ifdef SHIFT_RGST_PARITY_EN
    logic          par;

    modport master (output clr, start, op, amt, d, sin,
                    input  q, sout, busy, done, par);
    modport slave  (input  clr, start, op, amt, d, sin,
                    output q, sout, busy, done, par);
`else
    modport master (output clr, start, op, amt, d, sin,
                    input  q, sout, busy, done);
    modport slave  (input  clr, start, op, amt, d, sin,
                    output q, sout, busy, done);
`endif

endinterface

// File: rtl/shift_rgst_step.sv
// Combinational single-bit step of the shift register: given the
// current contents, the operation and the serial fill bit, produce the
// next contents and the bit that leaves across the boundary.
module shift_rgst_step
    import shift_rgst_pkg::*;
#(
    parameter int w = 8
) (
    input  op_e          op_i,
    input  logic [w-1:0] q_i,
    input  logic         sin_i,
    output logic [w-1:0] q_nxt_o,
    output logic         out_bit_o
);

    // One-bit shift/rotate; non-shift codes leave the value untouched.
    always_comb begin
        q_nxt_o   = q_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                q_nxt_o   = {q_i[w-2:0], sin_i};
                out_bit_o = q_i[w-1];
            end
            OP_SHR: begin
                q_nxt_o   = {sin_i, q_i[w-1:1]};
                out_bit_o = q_i[0];
            end
            OP_SAR: begin
                q_nxt_o   = {q_i[w-1], q_i[w-1:1]};
                out_bit_o = q_i[0];
            end
            OP_ROL: begin
                q_nxt_o   = {q_i[w-2:0], q_i[w-1]};
                out_bit_o = q_i[w-1];
            end
            OP_ROR: begin
                q_nxt_o   = {q_i[0], q_i[w-1:1]};
                out_bit_o = q_i[0];
            end
            default: begin
                q_nxt_o   = q_i;
                out_bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_rgst.sv
// Multi-mode shift register with start/busy/done handshake. Shifts and
// rotates take one cycle per bit position; clr aborts any operation.
// Optional feature: define SHIFT_RGST_PARITY_EN to add the registered
// parity output par (always equal to ^q).
module shift_rgst
    import shift_rgst_pkg::*;
#(
    parameter int           w  = 8,
    parameter logic [w-1:0] iv = '0
) (
    input  logic        clk,
    input  logic        rst,
    shift_rgst_if.slave bus
);

    localparam int            AW      = calc_aw(w);
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [w-1:0]  q_q, q_d;
    logic          sout_q, sout_d;
    logic [w-1:0]  step_q;
    logic          step_out;

    // The step unit always works on the latched op; its result is only
    // used while in RUN.
    shift_rgst_step #(.w(w)) u_step (
        .op_i      (op_q),
        .q_i       (q_q),
        .sin_i     (bus.sin),
        .q_nxt_o   (step_q),
        .out_bit_o (step_out)
    );

    // Next-state logic: start decode in IDLE, stepping in RUN, clr overrides all.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_HOLD: state_d = ST_DONE;
                        OP_LOAD: begin
                            q_d     = bus.d;
                            state_d = ST_DONE;
                        end
                        OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                            if (bus.amt == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                op_d    = op_e'(bus.op);
                                cnt_d   = bus.amt;
                                state_d = ST_RUN;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                q_d    = step_q;
                sout_d = step_out;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.clr) begin
            q_d     = iv;
            sout_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            q_q     <= iv;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
        end
    end

`ifdef SHIFT_RGST_PARITY_EN
    logic par_q;

    // Parity is taken from next-q so it updates on the same edge as q.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= ^iv;
        end else begin
            par_q <= ^q_d;
        end
    end

    assign bus.par = par_q;
`endif

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);

endmodule
